// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if
//   Handshake bundle between fetch, the fetch/decode queue and decode.
//   master : fetch + decode side (drives in_*, out_ready, flush)
//   slave  : the queue itself (drives in_ready, out_*, count)
//   Signals:
//     flush               redirect taken, discard all buffered entries
//     in_valid/in_ready   fetch push handshake (in_ready drives fetch En)
//     in_pc, in_instr     fetched {PC, instruction} pair
//     out_valid/out_ready decode pop handshake
//     out_pc, out_instr   head entry (zero when out_valid=0)
//     count               occupied entries, 0..DEPTH
interface fetch_decode_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready;
    logic [AW:0]   count;

    modport master (
        output flush,
        output in_valid,
        output in_pc,
        output in_instr,
        input  in_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_pc,
        input  in_instr,
        output in_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready,
        output count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Circular FIFO of {PC, instruction} pairs between fetch and decode, so a
//   decode stall does not immediately freeze the PC.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    fetch_decode_queue_if.slave (flush, push/pop handshakes, count)
//   Parameters:
//     DEPTH  entries, power of two, >= 2 (AW = log2(DEPTH) is derived)
//   Build option:
//     FDQ_BYPASS_EN  when defined, an empty queue with decode ready passes the
//                    incoming pair straight to the outputs in the same cycle
//                    without storing it.
//   Priority: reset > flush > push/pop. A full queue refuses pushes even when
//   decode pops in the same cycle, so in_ready depends on registered state only.
module fetch_decode_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    fetch_decode_queue_if.slave       bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;

    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    logic          out_valid_c;
    logic [31:0]   out_pc_c;
    logic [31:0]   out_instr_c;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

`ifdef FDQ_BYPASS_EN
    // Empty queue and decode ready: hand the pair straight through, skip storage.
    assign bypass = empty & bus.in_valid & ~bus.flush & bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    // push/pop are qualified by flush in the register process, not here.
    assign push = bus.in_valid & ~full & ~bypass;
    assign pop  = ~empty & bus.out_ready;

    assign head = mem[rd_ptr];

    always_comb begin
        out_valid_c = 1'b0;
        out_pc_c    = '0;
        out_instr_c = '0;
        if (!empty) begin
            out_valid_c = 1'b1;
            out_pc_c    = head[63:32];
            out_instr_c = head[31:0];
        end else if (bypass) begin
            out_valid_c = 1'b1;
            out_pc_c    = bus.in_pc;
            out_instr_c = bus.in_instr;
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_pc_c;
    assign bus.out_instr = out_instr_c;
    assign bus.count     = count_q;

    // Storage is never cleared; only pointers and count are reset/flushed.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && push) begin
            mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers are AW bits wide, so wrap at DEPTH is implicit.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
